spi_reg_sequencer: RTL
======================

Name: spi_reg_sequencer

Overview:
- Register-access controller in the SPI clock domain; sequences MOSI/MISO bit traffic into a framed command protocol over a small register file.
- Protocol:
  - Byte 0 of each CS_n-low frame is a command {RW, ADDR[6:0]}, with RW=1 for read.
  - Following bytes are write data or read data.
  - The address auto-increments per data byte.
- Register contents are exported to the fabric as a quasi-static bus. Write events are exported as a toggle for CDC in the i_Clk domain.

Parameters:
- DEPTH, 16, number of 8-bit registers (1..128).
- STATUS_ID, 8'hA4, status byte shifted out during the command byte; bit 0 is replaced by the error flag.

Ports:
- w_SPI_Clk  in  1  SPI clock already normalised for mode; posedge = capture edge.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_SPI_CS_n  in  1  frame select, active low; high asynchronously clears frame state.
- i_SPI_MOSI  in  1  serial data in, MSb first.
- o_SPI_MISO  out  1  serial data out, MSb first; 1'bZ while i_SPI_CS_n=1.
- o_Regs  out  DEPTH*8  register file, reg k at [8k+7:8k].
- o_Wr_Addr  out  7  address of the last committed write.
- o_Wr_Toggle  out  1  inverts once per committed write.
- o_Err  out  1  sticky error flag.

Behaviour:
- Reset (i_Rst_L=0, async): all of the following are cleared.
  - o_Regs=0, o_Wr_Addr=0, o_Wr_Toggle=0, o_Err=0.
  - Frame state: bit_cnt=0, in_data=0, rw=0, addr=0, tx_shift=0.
  - Takes priority over CS_n and clock.
- Frame clear (i_SPI_CS_n=1, async): bit_cnt=0, in_data=0, tx_shift=0.
  - o_Regs, o_Err, o_Wr_* are untouched.
- Each posedge w_SPI_Clk with CS_n=0:
  - Sample MOSI into rx_shift.
  - bit_cnt increments 0..7 and wraps.
- MISO mux:
  - in_data=0: outputs status[7-bit_cnt], where status={STATUS_ID[7:1], o_Err}.
  - in_data=1: outputs tx_shift[7].
  - With no edge yet after CS_n falls, status bit 7 is already driven (preload).
- Command completion (bit_cnt=7, in_data=0), next-state values:
  - rw = rx_shift[6], addr = {rx_shift[5:0], MOSI}, in_data = 1.
  - If the address is in range (< DEPTH): tx_shift = reg[addr] when rw=1, else 0.
  - If the address is out of range (>= DEPTH): o_Err=1, tx_shift=0, and the frame enters discard mode.
    - In discard mode, writes are ignored and reads return 8'h00 for the rest of the frame.
  - o_Err clear-on-read: o_Err is cleared at this edge when the address is valid. Set wins over clear on the same edge.
- Data byte completion (bit_cnt=7, in_data=1):
  - Write (rw=0, not discard):
    - reg[addr] = {rx_shift[6:0], MOSI}; visible on o_Regs after this edge.
    - o_Wr_Addr = addr, o_Wr_Toggle inverts.
  - Read (rw=1, not discard): tx_shift = reg[addr_next].
  - Both cases: addr_next = (addr==DEPTH-1) ? 0 : addr+1; addr = addr_next. Wrap stays inside the file.
- Data byte bits 0..6 during a read: tx_shift shifts left by 1 and fills with 0.
- Read data uses the register value at the load edge. A write in the same frame is never concurrent, because a frame is either read or write.
- Partial byte at CS_n rise: discarded, no register change, no toggle.
- Latency:
  - A written byte appears on o_Regs at its 8th capture edge.
  - The first read-data MSb is on MISO immediately after the command's 8th edge.
- Throughput: unlimited consecutive data bytes per frame, with auto-increment and wrap.
- o_Regs and o_Wr_Addr are stable for at least 8 SPI clocks after any toggle. Consumers synchronise o_Wr_Toggle (2-FF) and then sample.

Test Plan:
- Reset then frame cmd 8'h03 (write addr 3), data 8'h5A -> o_Regs[31:24]=8'h5A, o_Wr_Addr=3, o_Wr_Toggle 0->1; MISO during cmd = 8'hA4.
- Burst write cmd 8'h0E, data 11,22,33 with DEPTH=16 -> reg14=8'h11, reg15=8'h22, reg0=8'h33 (wrap); toggle inverts 3 times.
- Read cmd 8'h8E after previous test -> MISO data bytes 8'h11, 8'h22, 8'h33; no toggle change.
- Out-of-range write cmd 8'h20, data 8'hFF -> no register change, o_Err=1. Next frame's status byte = 8'hA5; valid cmd in that frame clears o_Err.
- CS_n rises after 5 bits of a data byte -> that register is unchanged, toggle unchanged; next frame decodes its command correctly from bit 0.
- Assert i_Rst_L low mid-burst -> all o_Regs=0, o_Err=0, o_Wr_Toggle=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/spi_reg_sequencer.sv
// SPI-domain register access sequencer: framed {RW, ADDR} command byte followed by
// auto-incrementing data bytes over a DEPTH x 8-bit register file.
module spi_reg_sequencer #(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  STATUS_ID = 8'hA4
) (
  input  logic               w_SPI_Clk,
  input  logic               i_Rst_L,
  input  logic               i_SPI_CS_n,
  input  logic               i_SPI_MOSI,
  output logic               o_SPI_MISO,
  output logic [DEPTH*8-1:0] o_Regs,
  output logic [6:0]         o_Wr_Addr,
  output logic               o_Wr_Toggle,
  output logic               o_Err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {PH_CMD, PH_DATA, PH_DISCARD} phase_e;

  phase_e      phase_q, phase_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_q, tx_d;
  logic [6:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  regs_q [DEPTH];
  logic [7:0]  regs_d [DEPTH];
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic        wr_toggle_q, wr_toggle_d;
  logic        err_q, err_d;

  logic [6:0]  cmd_addr;
  logic        cmd_in_range;
  logic [6:0]  addr_next;
  logic [7:0]  status;
  logic        miso_bit;
  logic        frame_rst_n;

  assign cmd_addr     = {rx_q[5:0], i_SPI_MOSI};
  assign cmd_in_range = ({1'b0, cmd_addr} < 8'(DEPTH));
  assign addr_next    = (addr_q == 7'(DEPTH - 1)) ? 7'd0 : addr_q + 7'd1;
  assign status       = {STATUS_ID[7:1], err_q};

  // Frame state is held in reset whenever CS_n is high, so a new frame always starts at bit 0.
  assign frame_rst_n  = i_Rst_L & ~i_SPI_CS_n;

  always_comb begin
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_addr_d   = wr_addr_q;
    wr_toggle_d = wr_toggle_q;
    err_d       = err_q;
    if (!i_SPI_CS_n) begin
      rx_d      = {rx_q[5:0], i_SPI_MOSI};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (phase_q != PH_CMD) tx_d = {tx_q[6:0], 1'b0};
      if (bit_cnt_q == 3'd7) begin
        if (phase_q == PH_CMD) begin
          rw_d   = rx_q[6];
          addr_d = cmd_addr;
          if (cmd_in_range) begin
            phase_d = PH_DATA;
            tx_d    = rx_q[6] ? regs_q[cmd_addr[AW-1:0]] : 8'h00;
            err_d   = 1'b0;
          end else begin
            phase_d = PH_DISCARD;
            tx_d    = 8'h00;
            err_d   = 1'b1;
          end
        end else begin
          addr_d = addr_next;
          tx_d   = 8'h00;
          if (phase_q == PH_DATA) begin
            if (rw_q) begin
              tx_d = regs_q[addr_next[AW-1:0]];
            end else begin
              regs_d[addr_q[AW-1:0]] = {rx_q, i_SPI_MOSI};
              wr_addr_d              = addr_q;
              wr_toggle_d            = ~wr_toggle_q;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      phase_q   <= PH_CMD;
      bit_cnt_q <= 3'd0;
      tx_q      <= 8'h00;
    end else begin
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_q        <= 7'd0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= 8'h00;
      wr_addr_q   <= 7'd0;
      wr_toggle_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_addr_q   <= wr_addr_d;
      wr_toggle_q <= wr_toggle_d;
      err_q       <= err_d;
    end
  end

  // The status byte MSb is presented as soon as CS_n falls, before any clock edge.
  assign miso_bit   = (phase_q == PH_CMD) ? status[~bit_cnt_q] : tx_q[7];
  assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : miso_bit;

  for (genvar k = 0; k < DEPTH; k++) begin : g_regs_out
    assign o_Regs[8*k +: 8] = regs_q[k];
  end

  assign o_Wr_Addr   = wr_addr_q;
  assign o_Wr_Toggle = wr_toggle_q;
  assign o_Err       = err_q;

endmodule
